// File: rtl/vga_sync_timing_checker.sv
// VGA sync timing checker: measures incoming hsync/vsync timing,
// compares it with the expected mode, tracks lock and recovers x/y.
module vga_sync_timing_checker #(
  parameter int COUNTER_SIZE = 11,
  parameter int H_TOTAL      = 1328,
  parameter int H_SYNC       = 136,
  parameter int V_TOTAL      = 806,
  parameter int SYNC_ACTIVE  = 0,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic                    control_clock,
  input  logic                    control_reset_n,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  output logic [COUNTER_SIZE-1:0] x_pos,
  output logic [COUNTER_SIZE-1:0] y_pos,
  output logic                    frame_start,
  output logic                    locked,
  output logic                    lock_lost,
  output logic [7:0]              error_count
);

  localparam logic ACT = SYNC_ACTIVE[0];
  localparam logic [COUNTER_SIZE-1:0] X_MAX  = '1;
  localparam logic [COUNTER_SIZE-1:0] X_PRE  = X_MAX - 1'b1;
  localparam logic [COUNTER_SIZE-1:0] H_LAST =
    COUNTER_SIZE'(H_TOTAL - 1);
  localparam logic [COUNTER_SIZE-1:0] W_LAST =
    COUNTER_SIZE'(H_SYNC - 1);
  localparam logic [COUNTER_SIZE-1:0] V_TOT  =
    COUNTER_SIZE'(V_TOTAL);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  state_t     state;
  logic [2:0] hs_q;
  logic [2:0] vs_q;
  logic [3:0] good_frames;
  logic       line_armed;
  logic       width_armed;
  logic       frame_bad;

  logic h_lead;
  logic h_trail;
  logic v_lead;
  logic len_err;
  logic wid_err;
  logic tmo_err;
  logic frm_err;
  logic err;

  // [1] is the synchronized level, [2] its previous value for edges
  assign h_lead  = (hs_q[1] == ACT) && (hs_q[2] != ACT);
  assign h_trail = (hs_q[1] != ACT) && (hs_q[2] == ACT);
  assign v_lead  = (vs_q[1] == ACT) && (vs_q[2] != ACT);

  always_comb begin
    len_err = 1'b0;
    wid_err = 1'b0;
    tmo_err = 1'b0;
    frm_err = 1'b0;
    if (h_lead && line_armed && x_pos != H_LAST)
      len_err = 1'b1;
    if (h_trail && width_armed && x_pos != W_LAST)
      wid_err = 1'b1;
    if (!h_lead && x_pos == X_PRE)
      tmo_err = 1'b1;
    if (v_lead && state != SEARCH && y_pos != V_TOT)
      frm_err = 1'b1;
    err = (state != SEARCH) &&
          (len_err || wid_err || tmo_err || frm_err);
  end

  always_ff @(posedge control_clock or negedge control_reset_n) begin
    if (!control_reset_n) begin
      state       <= SEARCH;
      hs_q        <= {3{~ACT}};
      vs_q        <= {3{~ACT}};
      good_frames <= '0;
      line_armed  <= 1'b0;
      width_armed <= 1'b0;
      frame_bad   <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      lock_lost   <= 1'b0;
      error_count <= '0;
    end else begin
      hs_q        <= {hs_q[1:0], hsync_in};
      vs_q        <= {vs_q[1:0], vsync_in};
      frame_start <= v_lead;
      lock_lost   <= 1'b0;

      if (h_lead)
        x_pos <= '0;
      else if (x_pos != X_MAX)
        x_pos <= x_pos + 1'b1;

      if (v_lead)
        y_pos <= h_lead ? COUNTER_SIZE'(1) : '0;
      else if (h_lead && y_pos != X_MAX)
        y_pos <= y_pos + 1'b1;

      if (h_lead)
        width_armed <= 1'b1;
      else if (h_trail)
        width_armed <= 1'b0;

      if (h_lead)
        line_armed <= 1'b1;

      if (err && error_count != 8'hff)
        error_count <= error_count + 8'd1;

      if (v_lead)
        frame_bad <= 1'b0;
      else if (err)
        frame_bad <= 1'b1;

      unique case (state)
        SEARCH: begin
          if (v_lead) begin
            state       <= VERIFY;
            good_frames <= '0;
          end
        end
        VERIFY: begin
          if (err) begin
            good_frames <= '0;
          end else if (v_lead && !frame_bad) begin
            if (good_frames + 4'd1 >= LOCK_N) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
            good_frames <= good_frames + 4'd1;
          end
        end
        LOCKED: begin
          if (err) begin
            state      <= SEARCH;
            locked     <= 1'b0;
            lock_lost  <= 1'b1;
            line_armed <= 1'b0;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_timing_checker.sv
// Bench for vga_sync_timing_checker: a small-mode sync generator,
// per-frame vector table and hand sequences for edge cases.
module tb_vga_sync_timing_checker;

  localparam int CS = 11;
  localparam int HT = 20;
  localparam int HS = 4;
  localparam int VT = 6;

  logic          clk;
  logic          rst_n;
  logic          hs;
  logic          vs;
  logic [CS-1:0] x_pos;
  logic [CS-1:0] y_pos;
  logic          frame_start;
  logic          locked;
  logic          lock_lost;
  logic [7:0]    error_count;

  int n_chk;
  int n_pass;
  int lost_cnt;

  typedef struct {
    bit rst;
    int nl;
    int odd;
    int olen;
    int ow;
    int e_lock;
    int e_err;
    int e_lost;
  } vec_t;

  vec_t tbl[15];

  vga_sync_timing_checker #(
    .COUNTER_SIZE(CS),
    .H_TOTAL(HT),
    .H_SYNC(HS),
    .V_TOTAL(VT),
    .SYNC_ACTIVE(0),
    .LOCK_FRAMES(2)
  ) dut (
    .control_clock(clk),
    .control_reset_n(rst_n),
    .hsync_in(hs),
    .vsync_in(vs),
    .x_pos(x_pos),
    .y_pos(y_pos),
    .frame_start(frame_start),
    .locked(locked),
    .lock_lost(lock_lost),
    .error_count(error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && lock_lost)
      lost_cnt++;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic send_line(input int len, input int w,
                           input bit vline);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      hs = (i < w) ? 1'b0 : 1'b1;
      vs = vline ? 1'b0 : 1'b1;
    end
  endtask

  task automatic send_frame(input int nl, input int odd,
                            input int olen, input int ow);
    for (int l = 0; l < nl; l++) begin
      if (l == odd)
        send_line(olen, ow, l == 0);
      else
        send_line(HT, HS, l == 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    lost_cnt = 0;
    rst_n    = 1'b0;
    hs       = 1'b1;
    vs       = 1'b1;

    // rst nl odd olen ow lock err lost
    tbl[0]  = '{0, 6, -1, 20, 4, 0, 0, 0};
    tbl[1]  = '{0, 6, -1, 20, 4, 1, 0, 0};
    tbl[2]  = '{0, 6,  2, 21, 4, 0, 1, 1};
    tbl[3]  = '{0, 6, -1, 20, 4, 0, 1, 1};
    tbl[4]  = '{0, 6, -1, 20, 4, 0, 1, 1};
    tbl[5]  = '{0, 6, -1, 20, 4, 1, 1, 1};
    tbl[6]  = '{0, 6,  1, 20, 3, 0, 2, 2};
    tbl[7]  = '{0, 6,  1, 20, 3, 0, 3, 2};
    tbl[8]  = '{0, 6, -1, 20, 4, 0, 3, 2};
    tbl[9]  = '{0, 6, -1, 20, 4, 0, 3, 2};
    tbl[10] = '{0, 6, -1, 20, 4, 1, 3, 2};
    tbl[11] = '{1, 5, -1, 20, 4, 0, 0, 2};
    tbl[12] = '{0, 6, -1, 20, 4, 0, 1, 2};
    tbl[13] = '{0, 6, -1, 20, 4, 0, 1, 2};
    tbl[14] = '{0, 6, -1, 20, 4, 1, 1, 2};

    #3;
    chk("rst x_pos", int'(x_pos), 0);
    chk("rst y_pos", int'(y_pos), 0);
    chk("rst frame_start", int'(frame_start), 0);
    chk("rst locked", int'(locked), 0);
    chk("rst lock_lost", int'(lock_lost), 0);
    chk("rst error_count", int'(error_count), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // first frame: edge latency, frame_start pulse, x wrap
    fork
      send_frame(VT, -1, HT, HS);
      begin
        repeat (4) @(negedge clk);
        chk("lat x_pos", int'(x_pos), 0);
        chk("lat y_pos", int'(y_pos), 1);
        chk("frame_start on", int'(frame_start), 1);
        @(negedge clk);
        chk("x_pos step", int'(x_pos), 1);
        chk("frame_start off", int'(frame_start), 0);
        repeat (18) @(negedge clk);
        chk("x_pos last", int'(x_pos), HT - 1);
        @(negedge clk);
        chk("x_pos wrap", int'(x_pos), 0);
        chk("y_pos line2", int'(y_pos), 2);
      end
    join
    chk("f0 locked", int'(locked), 0);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) begin
        do_reset();
        repeat (3) @(negedge clk);
      end
      send_frame(tbl[i].nl, tbl[i].odd, tbl[i].olen, tbl[i].ow);
      chk($sformatf("row%0d locked", i), int'(locked),
          tbl[i].e_lock);
      chk($sformatf("row%0d errors", i), int'(error_count),
          tbl[i].e_err);
      chk($sformatf("row%0d lost", i), lost_cnt, tbl[i].e_lost);
    end

    // hsync stops: timeout while locked
    repeat (2100) @(negedge clk);
    chk("tmo x_pos", int'(x_pos), 2047);
    chk("tmo errors", int'(error_count), 2);
    chk("tmo locked", int'(locked), 0);
    chk("tmo lost", lost_cnt, 3);
    repeat (50) @(negedge clk);
    chk("tmo once", int'(error_count), 2);

    // many bad-width lines in VERIFY: counter saturates
    send_line(HT, HS, 1'b1);
    for (int i = 0; i < 300; i++)
      send_line(HT, 3, 1'b0);
    chk("sat errors", int'(error_count), 255);

    // asynchronous reset mid-line
    send_line(HT, HS, 1'b0);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst x_pos", int'(x_pos), 0);
    chk("arst y_pos", int'(y_pos), 0);
    chk("arst locked", int'(locked), 0);
    chk("arst errors", int'(error_count), 0);
    chk("arst frame_start", int'(frame_start), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
